// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the stopwatch time counter:
//                control-FSM state encoding, BCD field width, per-field
//                terminal values and a small integer-to-BCD helper.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    // Control FSM states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RUN         = 3'd1,
        STOPPED     = 3'd2,
        LAP         = 3'd3,
        LAP_STOPPED = 3'd4
    } state_t;

    localparam int                   BCD_WIDTH = 8;
    localparam logic [BCD_WIDTH-1:0] CS_MAX    = 8'h99;
    localparam logic [BCD_WIDTH-1:0] SEC_MAX   = 8'h59;

    // Converts 0..99 into two packed BCD digits {tens, ones}.
    function automatic logic [BCD_WIDTH-1:0] to_bcd2(input int unsigned value);
        int unsigned tens;
        int unsigned ones;
        tens = value / 10;
        ones = value % 10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_mod_counter
//  Description : Two-digit BCD counter that counts 00..MAX_BCD and wraps to
//                00. o_carry is high in the cycle an enabled count wraps, so
//                instances chain by feeding o_carry into the next i_en.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-high reset
//                i_en     - advance by one this cycle
//                i_clr    - synchronous clear (priority over i_en)
//                o_count  - current value, two BCD digits
//                o_carry  - wrap indication (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_WIDTH-1:0] MAX_BCD = 8'h99
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_clr,
    output logic [BCD_WIDTH-1:0] o_count,
    output logic                 o_carry
);

    logic [BCD_WIDTH-1:0] r_count;
    logic [BCD_WIDTH-1:0] w_count_inc;
    logic                 w_at_max;

    assign w_at_max = (r_count == MAX_BCD);

    // Decimal increment: the ones digit rolls 9 -> 0 and bumps the tens digit.
    always_comb begin
        w_count_inc = r_count;
        if (r_count[3:0] == 4'd9) begin
            w_count_inc = {r_count[7:4] + 4'd1, 4'd0};
        end else begin
            w_count_inc = {r_count[7:4], r_count[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_max ? '0 : w_count_inc;
        end
    end

    assign o_count = r_count;
    assign o_carry = i_en && w_at_max;

endmodule : bcd_mod_counter
`default_nettype wire

// File: rtl/stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_time_counter
//  Description : Turns the 100 Hz square wave into a one-cycle tick in the
//                CLK_50_MHz domain and accumulates elapsed time as BCD
//                MM:SS.cc under a start/stop/lap/clear control FSM. Outputs
//                show the live count, or the captured lap value while a lap
//                view is active.
//  Ports       : CLK_50_MHz   - system clock, rising edge
//                reset        - synchronous active-high reset
//                clk_100hz_in - 100 Hz square wave from the divider
//                start_stop   - one-cycle pulse, toggles run/stop
//                lap          - one-cycle pulse, freezes/releases display
//                clear        - one-cycle pulse, zero the count
//                cs_bcd       - centiseconds, BCD 00..99
//                sec_bcd      - seconds, BCD 00..59
//                min_bcd      - minutes, BCD 00..MINUTE_LIMIT-1
//                running      - high in RUN or LAP
//                lap_active   - high in LAP or LAP_STOPPED
//                overflow     - sticky, set when the count wraps past max
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES  = 0,
    parameter int MINUTE_LIMIT = 60
) (
    input  logic                 CLK_50_MHz,
    input  logic                 reset,
    input  logic                 clk_100hz_in,
    input  logic                 start_stop,
    input  logic                 lap,
    input  logic                 clear,
    output logic [BCD_WIDTH-1:0] cs_bcd,
    output logic [BCD_WIDTH-1:0] sec_bcd,
    output logic [BCD_WIDTH-1:0] min_bcd,
    output logic                 running,
    output logic                 lap_active,
    output logic                 overflow
);

    localparam logic [BCD_WIDTH-1:0] c_min_max = to_bcd2(MINUTE_LIMIT - 1);

    // ------------------------------------------------------------------
    // Input conditioning and rising-edge detect
    // ------------------------------------------------------------------
    logic w_in_sync;
    logic r_prev;
    logic w_tick;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_in_sync = clk_100hz_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge CLK_50_MHz) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= clk_100hz_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_in_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // prev is only cleared by reset; clear must not create a spurious edge.
    always_ff @(posedge CLK_50_MHz) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_in_sync;
        end
    end

    assign w_tick = w_in_sync && !r_prev;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_lap;
    state_t w_state_next;
    logic   w_capture;

    // lap is applied first; start_stop then acts on the post-lap state.
    always_comb begin
        w_state_lap  = r_state;
        w_state_next = r_state;
        w_capture    = 1'b0;

        if (lap) begin
            case (r_state)
                RUN: begin
                    w_state_lap = LAP;
                    w_capture   = 1'b1;
                end
                LAP:         w_state_lap = RUN;
                LAP_STOPPED: w_state_lap = STOPPED;
                default:     w_state_lap = r_state;
            endcase
        end

        w_state_next = w_state_lap;
        if (start_stop) begin
            case (w_state_lap)
                IDLE:        w_state_next = RUN;
                RUN:         w_state_next = STOPPED;
                STOPPED:     w_state_next = RUN;
                LAP:         w_state_next = LAP_STOPPED;
                LAP_STOPPED: w_state_next = LAP;
                default:     w_state_next = IDLE;
            endcase
        end

        if (clear) begin
            w_state_next = IDLE;
            w_capture    = 1'b0;
        end
    end

    always_ff @(posedge CLK_50_MHz) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Time count: cs -> sec -> min carry chain
    // ------------------------------------------------------------------
    logic                 w_count_en;
    logic                 w_cs_carry;
    logic                 w_sec_carry;
    logic                 w_min_carry;
    logic [BCD_WIDTH-1:0] w_cs;
    logic [BCD_WIDTH-1:0] w_sec;
    logic [BCD_WIDTH-1:0] w_min;

    // Gated by the registered state so a coincident start_stop cannot
    // change whether this tick counts.
    assign w_count_en = w_tick && ((r_state == RUN) || (r_state == LAP));

    bcd_mod_counter #(.MAX_BCD(CS_MAX)) u_cs_counter (
        .clk     (CLK_50_MHz),
        .rst     (reset),
        .i_en    (w_count_en),
        .i_clr   (clear),
        .o_count (w_cs),
        .o_carry (w_cs_carry)
    );

    bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec_counter (
        .clk     (CLK_50_MHz),
        .rst     (reset),
        .i_en    (w_cs_carry),
        .i_clr   (clear),
        .o_count (w_sec),
        .o_carry (w_sec_carry)
    );

    bcd_mod_counter #(.MAX_BCD(c_min_max)) u_min_counter (
        .clk     (CLK_50_MHz),
        .rst     (reset),
        .i_en    (w_sec_carry),
        .i_clr   (clear),
        .o_count (w_min),
        .o_carry (w_min_carry)
    );

    logic r_overflow;

    always_ff @(posedge CLK_50_MHz) begin
        if (reset || clear) begin
            r_overflow <= 1'b0;
        end else if (w_min_carry) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Lap capture and display mux
    // ------------------------------------------------------------------
    logic [BCD_WIDTH-1:0] r_lap_cs;
    logic [BCD_WIDTH-1:0] r_lap_sec;
    logic [BCD_WIDTH-1:0] r_lap_min;

    always_ff @(posedge CLK_50_MHz) begin
        if (reset || clear) begin
            r_lap_cs  <= '0;
            r_lap_sec <= '0;
            r_lap_min <= '0;
        end else if (w_capture) begin
            r_lap_cs  <= w_cs;
            r_lap_sec <= w_sec;
            r_lap_min <= w_min;
        end
    end

    logic w_lap_view;

    assign w_lap_view = (r_state == LAP) || (r_state == LAP_STOPPED);

    assign cs_bcd     = w_lap_view ? r_lap_cs  : w_cs;
    assign sec_bcd    = w_lap_view ? r_lap_sec : w_sec;
    assign min_bcd    = w_lap_view ? r_lap_min : w_min;
    assign running    = (r_state == RUN) || (r_state == LAP);
    assign lap_active = w_lap_view;
    assign overflow   = r_overflow;

endmodule : stopwatch_time_counter
`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_time_counter
//  Description : Directed self-checking bench. Instance A uses a registered
//                source (SYNC_STAGES=0, MINUTE_LIMIT=60); instance B uses a
//                two-stage synchroniser and MINUTE_LIMIT=2 so the full wrap
//                to 00:00.00 is reachable in a short run. Both share inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_time_counter;

    logic       CLK_50_MHz;
    logic       reset;
    logic       clk_100hz_in;
    logic       start_stop;
    logic       lap;
    logic       clear;

    logic [7:0] a_cs, a_sec, a_min;
    logic       a_running, a_lap_active, a_overflow;
    logic [7:0] b_cs, b_sec, b_min;
    logic       b_running, b_lap_active, b_overflow;

    int checks   = 0;
    int failures = 0;

    stopwatch_time_counter #(.SYNC_STAGES(0), .MINUTE_LIMIT(60)) u_dut_a (
        .CLK_50_MHz   (CLK_50_MHz),
        .reset        (reset),
        .clk_100hz_in (clk_100hz_in),
        .start_stop   (start_stop),
        .lap          (lap),
        .clear        (clear),
        .cs_bcd       (a_cs),
        .sec_bcd      (a_sec),
        .min_bcd      (a_min),
        .running      (a_running),
        .lap_active   (a_lap_active),
        .overflow     (a_overflow)
    );

    stopwatch_time_counter #(.SYNC_STAGES(2), .MINUTE_LIMIT(2)) u_dut_b (
        .CLK_50_MHz   (CLK_50_MHz),
        .reset        (reset),
        .clk_100hz_in (clk_100hz_in),
        .start_stop   (start_stop),
        .lap          (lap),
        .clear        (clear),
        .cs_bcd       (b_cs),
        .sec_bcd      (b_sec),
        .min_bcd      (b_min),
        .running      (b_running),
        .lap_active   (b_lap_active),
        .overflow     (b_overflow)
    );

    initial CLK_50_MHz = 1'b0;
    always #10 CLK_50_MHz = ~CLK_50_MHz;

    // Advance one clock; inputs are changed and outputs sampled 1 ns later.
    task automatic step();
        @(posedge CLK_50_MHz);
        #1;
    endtask

    // n full input periods: one cycle high, one cycle low.
    task automatic periods(input int n);
        for (int i = 0; i < n; i++) begin
            clk_100hz_in = 1'b1;
            step();
            clk_100hz_in = 1'b0;
            step();
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1; step(); start_stop = 1'b0;
    endtask

    task automatic press_lap();
        lap = 1'b1; step(); lap = 1'b0;
    endtask

    task automatic press_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    // {min, sec, cs, running, lap_active, overflow}
    function automatic logic [26:0] a_vec();
        return {a_min, a_sec, a_cs, a_running, a_lap_active, a_overflow};
    endfunction

    function automatic logic [26:0] b_vec();
        return {b_min, b_sec, b_cs, b_running, b_lap_active, b_overflow};
    endfunction

    task automatic test_reset();
        reset = 1'b1; step(); step(); reset = 1'b0;
        checks++;
        if (a_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL reset_a: got %h required %h", a_vec(), {24'h000000, 3'b000});
        end
        checks++;
        if (b_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL reset_b: got %h required %h", b_vec(), {24'h000000, 3'b000});
        end
    endtask

    task automatic test_idle();
        periods(5);
        checks++;
        if (a_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL idle_no_count: got %h required %h", a_vec(), {24'h000000, 3'b000});
        end
    endtask

    task automatic test_run();
        press_ss();
        periods(150);
        checks++;
        if (a_vec() !== {24'h000150, 3'b100}) begin
            failures++;
            $display("FAIL run_150: got %h required %h", a_vec(), {24'h000150, 3'b100});
        end
    endtask

    task automatic test_lap();
        press_lap();
        checks++;
        if (a_vec() !== {24'h000150, 3'b110}) begin
            failures++;
            $display("FAIL lap_capture: got %h required %h", a_vec(), {24'h000150, 3'b110});
        end
        periods(100);
        checks++;
        if (a_vec() !== {24'h000150, 3'b110}) begin
            failures++;
            $display("FAIL lap_hold: got %h required %h", a_vec(), {24'h000150, 3'b110});
        end
        press_lap();
        checks++;
        if (a_vec() !== {24'h000250, 3'b100}) begin
            failures++;
            $display("FAIL lap_release: got %h required %h", a_vec(), {24'h000250, 3'b100});
        end
    endtask

    // lap and start_stop together in RUN: capture and land in LAP_STOPPED.
    task automatic test_lap_and_ss();
        lap = 1'b1; start_stop = 1'b1; step(); lap = 1'b0; start_stop = 1'b0;
        periods(10);
        checks++;
        if (a_vec() !== {24'h000250, 3'b010}) begin
            failures++;
            $display("FAIL lap_stopped: got %h required %h", a_vec(), {24'h000250, 3'b010});
        end
        press_lap();
        checks++;
        if (a_vec() !== {24'h000250, 3'b000}) begin
            failures++;
            $display("FAIL lapstop_to_stopped: got %h required %h", a_vec(), {24'h000250, 3'b000});
        end
        press_ss();
        periods(1);
        checks++;
        if (a_vec() !== {24'h000251, 3'b100}) begin
            failures++;
            $display("FAIL resume_run: got %h required %h", a_vec(), {24'h000251, 3'b100});
        end
    endtask

    task automatic test_clear();
        clk_100hz_in = 1'b1; start_stop = 1'b1; clear = 1'b1;
        step();
        clk_100hz_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
        checks++;
        if (a_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL clear_priority: got %h required %h", a_vec(), {24'h000000, 3'b000});
        end
        periods(3);
        checks++;
        if (a_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL clear_idle: got %h required %h", a_vec(), {24'h000000, 3'b000});
        end
    endtask

    task automatic test_stop_restart();
        press_ss();
        periods(37);
        press_ss();
        periods(50);
        checks++;
        if (a_vec() !== {24'h000037, 3'b000}) begin
            failures++;
            $display("FAIL stopped_hold: got %h required %h", a_vec(), {24'h000037, 3'b000});
        end
        press_lap();
        checks++;
        if (a_vec() !== {24'h000037, 3'b000}) begin
            failures++;
            $display("FAIL stopped_lap_ignored: got %h required %h", a_vec(), {24'h000037, 3'b000});
        end
        press_ss();
        periods(1);
        checks++;
        if (a_vec() !== {24'h000038, 3'b100}) begin
            failures++;
            $display("FAIL restart: got %h required %h", a_vec(), {24'h000038, 3'b100});
        end
    endtask

    // A tick coinciding with start_stop is counted iff the old state counts.
    task automatic test_ss_with_tick();
        clk_100hz_in = 1'b1; start_stop = 1'b1; step();
        clk_100hz_in = 1'b0; start_stop = 1'b0;
        checks++;
        if (a_vec() !== {24'h000039, 3'b000}) begin
            failures++;
            $display("FAIL ss_tick_run: got %h required %h", a_vec(), {24'h000039, 3'b000});
        end
        step();
        clk_100hz_in = 1'b1; start_stop = 1'b1; step();
        clk_100hz_in = 1'b0; start_stop = 1'b0;
        checks++;
        if (a_vec() !== {24'h000039, 3'b100}) begin
            failures++;
            $display("FAIL ss_tick_stopped: got %h required %h", a_vec(), {24'h000039, 3'b100});
        end
        repeat (4) step();
    endtask

    task automatic test_sync_latency();
        press_clear();
        press_ss();
        clk_100hz_in = 1'b1; step();
        checks++;
        if ({a_cs, b_cs} !== 16'h0100) begin
            failures++;
            $display("FAIL sync_edge0: got a/b %h required %h", {a_cs, b_cs}, 16'h0100);
        end
        clk_100hz_in = 1'b0; step();
        checks++;
        if (b_cs !== 8'h00) begin
            failures++;
            $display("FAIL sync_edge1: got %h required %h", b_cs, 8'h00);
        end
        step();
        checks++;
        if (b_cs !== 8'h01) begin
            failures++;
            $display("FAIL sync_edge2: got %h required %h", b_cs, 8'h01);
        end
    endtask

    task automatic test_overflow();
        press_clear();
        press_ss();
        periods(11998);
        step(); step();
        checks++;
        if (b_vec() !== {24'h015998, 3'b100}) begin
            failures++;
            $display("FAIL near_max: got %h required %h", b_vec(), {24'h015998, 3'b100});
        end
        periods(1); step(); step();
        checks++;
        if (b_vec() !== {24'h015999, 3'b100}) begin
            failures++;
            $display("FAIL at_max: got %h required %h", b_vec(), {24'h015999, 3'b100});
        end
        periods(1); step(); step();
        checks++;
        if (b_vec() !== {24'h000000, 3'b101}) begin
            failures++;
            $display("FAIL wrap: got %h required %h", b_vec(), {24'h000000, 3'b101});
        end
        periods(3); step(); step();
        checks++;
        if (b_vec() !== {24'h000003, 3'b101}) begin
            failures++;
            $display("FAIL overflow_sticky: got %h required %h", b_vec(), {24'h000003, 3'b101});
        end
        // A saw 11998 + 1 + 1 + 3 = 12003 ticks: 02:00.03 without overflow.
        checks++;
        if (a_vec() !== {24'h020003, 3'b100}) begin
            failures++;
            $display("FAIL minute_carry: got %h required %h", a_vec(), {24'h020003, 3'b100});
        end
        press_clear();
        checks++;
        if (b_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL clear_overflow: got %h required %h", b_vec(), {24'h000000, 3'b000});
        end
    endtask

    task automatic test_reset_midcount();
        press_ss();
        lap = 1'b1; step(); lap = 1'b0;
        periods(7);
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if (a_vec() !== {24'h000000, 3'b000}) begin
            failures++;
            $display("FAIL reset_midlap: got %h required %h", a_vec(), {24'h000000, 3'b000});
        end
    endtask

    initial begin
        reset        = 1'b0;
        clk_100hz_in = 1'b0;
        start_stop   = 1'b0;
        lap          = 1'b0;
        clear        = 1'b0;
        test_reset();
        test_idle();
        test_run();
        test_lap();
        test_lap_and_ss();
        test_clear();
        test_stop_restart();
        test_ss_with_tick();
        test_sync_latency();
        test_overflow();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stopwatch_time_counter
`default_nettype wire
